// File: rtl/alu_pipe.sv
// alu_pipe: signed ALU with valid/ready on both sides and a one-entry registered output stage.
// Define ALU_PIPE_DIV_EN to build the iterative restoring divider; otherwise DIV returns ERR.
module alu_pipe #(
    parameter int WIDTH     = 16,
    parameter int RES_WIDTH = 2*WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [RES_WIDTH-1:0] RES,
    output logic [1:0]           RES_GROUP,
    output logic                 ERR
);
    localparam int PAD = RES_WIDTH - WIDTH;
    localparam logic [1:0] G_ARITH = 2'b00;
    localparam logic [1:0] G_LOGIC = 2'b01;
    localparam logic [1:0] G_CMP   = 2'b10;
    localparam logic [1:0] G_SHIFT = 2'b11;

    logic [RES_WIDTH-1:0] res_q, res_d;
    logic [1:0]           grp_q, grp_d;
    logic                 err_q, err_d;
    logic                 vld_q, vld_d;

    logic                 out_free, accept, load_alu;
    logic [RES_WIDTH-1:0] alu_res;
    logic                 alu_err;
    logic [RES_WIDTH-1:0] a_x, b_x;
    logic [1:0]           cmp_v;
    logic [WIDTH-1:0]     lw, sh;

    assign a_x      = {{PAD{A[WIDTH-1]}}, A};
    assign b_x      = {{PAD{B[WIDTH-1]}}, B};
    assign out_free = !vld_q || OUT_READY;
    assign accept   = IN_VALID && IN_READY;

    always_comb begin
        lw      = '0;
        sh      = '0;
        cmp_v   = '0;
        alu_res = '0;
        alu_err = 1'b0;
        case (ALU_FUN[1:0])
            2'b00:   lw = A & B;
            2'b01:   lw = A | B;
            2'b10:   lw = ~(A & B);
            default: lw = ~(A | B);
        endcase
        case (ALU_FUN[1:0])
            2'b00:   sh = A >> 1;
            2'b01:   sh = A << 1;
            2'b10:   sh = B >> 1;
            default: sh = B << 1;
        endcase
        case (ALU_FUN[1:0])
            2'b01:   cmp_v = ($signed(A) == $signed(B)) ? 2'd1 : 2'd0;
            2'b10:   cmp_v = ($signed(A) >  $signed(B)) ? 2'd2 : 2'd0;
            2'b11:   cmp_v = ($signed(A) <  $signed(B)) ? 2'd3 : 2'd0;
            default: cmp_v = 2'd0;
        endcase
        case (ALU_FUN[3:2])
            G_ARITH: begin
                case (ALU_FUN[1:0])
                    2'b00:   alu_res = a_x + b_x;
                    2'b01:   alu_res = a_x - b_x;
                    2'b10:   alu_res = $signed(a_x) * $signed(b_x);
                    default: begin
`ifdef ALU_PIPE_DIV_EN
                        // only loaded for B==0; nonzero divisors go through the iterative path
                        alu_res = {A, {WIDTH{1'b1}}};
`else
                        alu_res = '0;
`endif
                        alu_err = 1'b1;
                    end
                endcase
            end
            G_LOGIC: alu_res = {{PAD{1'b0}}, lw};
            G_CMP:   alu_res = {{(RES_WIDTH-2){1'b0}}, cmp_v};
            G_SHIFT: alu_res = {{PAD{1'b0}}, sh};
        endcase
    end

`ifdef ALU_PIPE_DIV_EN
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic                 negq_q, negq_d, negr_q, negr_d;
    logic [WIDTH:0]       shifted;
    logic                 take, is_div, start_div, div_done;
    logic [WIDTH-1:0]     rem_n, quo_n, q_fix, r_fix;
    logic [RES_WIDTH-1:0] div_res;

    assign is_div    = (ALU_FUN == 4'b0011);
    assign start_div = accept && is_div && (B != '0);
    assign div_done  = (state_q == BUSY) && (cnt_q == '0) && out_free;
    assign load_alu  = accept && !start_div;
    assign IN_READY  = !RST && (state_q == IDLE) && out_free;

    // one restoring step: quotient bits shift into quo_q as dividend bits shift out
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign take    = shifted >= {1'b0, dvs_q};
    assign rem_n   = take ? WIDTH'(shifted - {1'b0, dvs_q}) : WIDTH'(shifted);
    assign quo_n   = {quo_q[WIDTH-2:0], take};
    assign q_fix   = negq_q ? -quo_n : quo_n;
    assign r_fix   = negr_q ? -rem_n : rem_n;
    assign div_res = {r_fix, q_fix};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            IDLE: begin
                if (start_div) begin
                    state_d = BUSY;
                    cnt_d   = CW'(WIDTH-1);
                    rem_d   = '0;
                    quo_d   = A[WIDTH-1] ? -A : A;
                    dvs_d   = B[WIDTH-1] ? -B : B;
                    negq_d  = A[WIDTH-1] ^ B[WIDTH-1];
                    negr_d  = A[WIDTH-1];
                end
            end
            BUSY: begin
                // the last step is held (not advanced) until the output register can take it
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    rem_d = rem_n;
                    quo_d = quo_n;
                end else if (out_free) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end
`else
    assign load_alu = accept;
    assign IN_READY = !RST && out_free;
`endif

    always_comb begin
        vld_d = vld_q && !OUT_READY;
        res_d = res_q;
        grp_d = grp_q;
        err_d = err_q;
        if (load_alu) begin
            vld_d = 1'b1;
            res_d = alu_res;
            grp_d = ALU_FUN[3:2];
            err_d = alu_err;
        end
`ifdef ALU_PIPE_DIV_EN
        if (div_done) begin
            vld_d = 1'b1;
            res_d = div_res;
            grp_d = G_ARITH;
            err_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q <= 1'b0;
            res_q <= '0;
            grp_q <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            res_q <= res_d;
            grp_q <= grp_d;
            err_q <= err_d;
        end
    end

    assign OUT_VALID = vld_q;
    assign RES       = res_q;
    assign RES_GROUP = grp_q;
    assign ERR       = err_q;
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised signed ALU with valid/ready handshakes on both sides and a registered single-entry output stage. It keeps the existing 4-bit ALU function encoding, with the arithmetic, logic, compare and shift groups, but produces one unified result bus instead of four per-unit outputs. It adds an optional multi-cycle iterative divider. It sits between an operand source and a consumer, either of which may stall.

## Interface
Parameters:
- WIDTH, 16, operand width in bits (≥4, even).
- RES_WIDTH, 2*WIDTH, result width; fixed relation, not to be overridden.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operand/op presented.
- IN_READY  out  1  block accepts this cycle.
- A  in  WIDTH  signed operand A.
- B  in  WIDTH  signed operand B.
- ALU_FUN  in  4  [3:2] group (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] op.
- OUT_VALID  out  1  result held.
- OUT_READY  in  1  consumer takes result.
- RES  out  RES_WIDTH  result.
- RES_GROUP  out  2  copy of ALU_FUN[3:2] of the result.
- ERR  out  1  result is an error (divide by zero, or DIV compiled out).

## Operation
- Accept: an operation is accepted on a cycle where IN_VALID && IN_READY.
- Arith:
  - 00: ADD, A+B sign-extended to RES_WIDTH.
  - 01: SUB, A−B sign-extended to RES_WIDTH.
  - 10: MUL, full signed product.
  - 11: DIV, RES = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}. Quotient truncates toward zero; remainder takes the sign of A.
- Logic: AND, OR, NAND, NOR, each WIDTH bits wide, zero-extended.
- Cmp:
  - 00 → 0.
  - 01 → 1 if A==B, else 0.
  - 10 → 2 if A>B, else 0.
  - 11 → 3 if A<B, else 0.
  - All compares are signed; the result is zero-extended.
- Shift (logical, by 1, zero-extended): A>>1, A<<1, B>>1, B<<1.
- DIV by zero: RES = {A, all-ones}, ERR=1, single-cycle latency.
- DIV(−2^(W−1), −1): quotient = −2^(W−1) (wraps), remainder = 0, ERR=0.
- FSM states:
  - IDLE: accepts any op. A non-DIV op, or a DIV with B==0, loads the output register. A DIV with B≠0 goes to BUSY.
  - BUSY: restoring divide on operand magnitudes, one quotient bit per cycle, counter WIDTH−1→0. On count 0, signs are fixed up, the output register is loaded, and the FSM returns to IDLE.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY). This is combinational from OUT_READY.
- The output register holds RES, RES_GROUP and ERR stable while OUT_VALID && !OUT_READY.

## Timing
- Reset values: IN_READY=0 while RST is high, then 1. OUT_VALID=0, RES=0, RES_GROUP=0, ERR=0, state IDLE, counter 0.
- Non-DIV ops and divide-by-zero: OUT_VALID rises on the edge after accept (latency 1). Back-to-back accepts give one result per cycle when OUT_READY is held high.
- DIV with B≠0: OUT_VALID rises WIDTH+1 edges after accept. IN_READY stays 0 during BUSY.
- Simultaneous events: if OUT_VALID && OUT_READY && an accept occur in the same cycle, the old result drains and the new one loads on the same edge, with no bubble.
- BUSY completing while the output is full and not ready: stay in BUSY with count 0 until the output frees, then load.
- Reset mid-divide: the divide is abandoned and all outputs go to reset values immediately. No result is produced.

## Configuration
- ALU_PIPE_DIV_EN defined: iterative divider and BUSY state are built as above.
- Not defined: no divider logic or BUSY state. DIV completes in 1 cycle with RES=0, ERR=1. All other ops are unchanged.

## Test plan
- WIDTH=16, ADD A=0x7FFF, B=0x0001, OUT_READY=1: RES=0x00008000, ERR=0, OUT_VALID one edge after accept.
- MUL A=−3, B=7: RES=0xFFFFFFEB. Then CMP-LT with A=−3, B=7 back-to-back: RES=3 on the next cycle.
- DIV A=−7, B=2 (with ALU_PIPE_DIV_EN): IN_READY low for 16 cycles, OUT_VALID at accept+17, RES={0xFFFF, 0xFFFD}.
- DIV A=5, B=0: ERR=1, RES={0x0005, 0xFFFF}, latency 1. With the macro undefined, RES=0 and ERR=1.
- Backpressure: hold OUT_READY=0 with the result valid. IN_READY stays 0 and RES stays stable for 10 cycles. When OUT_READY rises alongside a new accept, the old result drains and the new result appears on the next edge.
- Assert RST at cycle 5 of a divide: OUT_VALID=0 and RES=0 asynchronously. After release, an ADD 1+1 gives RES=2.
